// File: rtl/sprite_attr_bank.sv
// sprite_attr_bank: double-buffered sprite attribute file on an Avalon-MM slave.
// Shadow bank is written by software; active bank is copied from it at frame boundaries.
module sprite_attr_bank #(
    parameter int NUM_SPRITES = 32,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    input  logic              vsync_start,
    input  logic [ADDR_W-1:0] disp_idx,
    output logic [DATA_W-1:0] disp_data,
    output logic              irq
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [ADDR_W-1:0] NUM_A    = ADDR_W'(NUM_SPRITES);
    localparam logic [ADDR_W-1:0] CTRL_A   = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  clr_idx;
    logic [DATA_W-1:0] shadow [NUM_SPRITES];
    logic [DATA_W-1:0] active [NUM_SPRITES];
    logic              commit_pending;
    logic [7:0]        frame_cnt;

    logic              is_spr;
    logic              is_ctrl;
    logic              wr_ok;
    logic              rd_ok;
    logic              spr_wr;
    logic              ctrl_wr;
    logic              start_clr;
    logic              do_commit;
    logic [DATA_W-1:0] status;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  d_idx;

    assign a_idx = address[IDX_W-1:0];
    assign d_idx = disp_idx[IDX_W-1:0];

    // Bus decode, stall generation and status word assembly
    always_comb begin
        is_spr      = address < NUM_A;
        is_ctrl     = address == CTRL_A;
        waitrequest = chipselect & (read | write) & (state == CLEAR) & is_spr;
        wr_ok       = chipselect & write & ~waitrequest;
        rd_ok       = chipselect & read & ~waitrequest;
        spr_wr      = wr_ok & is_spr;
        ctrl_wr     = wr_ok & is_ctrl;
        start_clr   = ctrl_wr & writedata[1] & (state == IDLE);
        do_commit   = vsync_start & commit_pending & (state == IDLE);
        status      = '0;
        status[0]   = commit_pending;
        status[1]   = state == CLEAR;
        status[2]   = irq;
        status[15:8] = frame_cnt;
    end

    // Clear sequencer next-state: sweep every shadow entry once, then return
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_clr) state_nxt = CLEAR;
            CLEAR: if (clr_idx == LAST_IDX) state_nxt = IDLE;
        endcase
    end

    // Clear sequencer state and sweep index
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (start_clr)
                clr_idx <= '0;
            else if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    // Shadow/active banks; commit copies pre-write shadow values
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (do_commit)
                for (int i = 0; i < NUM_SPRITES; i++)
                    active[i] <= shadow[i];
            if (spr_wr)
                shadow[a_idx] <= writedata;
            if (state == CLEAR)
                shadow[clr_idx] <= '0;
        end
    end

    // Commit bookkeeping; set of pending/irq wins over same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_pending <= 1'b0;
            irq            <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            if (do_commit)
                commit_pending <= 1'b0;
            if (ctrl_wr & writedata[0])
                commit_pending <= 1'b1;
            if (ctrl_wr & writedata[2])
                irq <= 1'b0;
            if (do_commit) begin
                irq       <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Registered bus readback; holds between accepted reads
    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_ok)
            readdata <= is_spr ? shadow[a_idx] : (is_ctrl ? status : '0);
    end

    // Registered display port from the active bank
    always_ff @(posedge clk) begin
        if (reset)
            disp_data <= '0;
        else
            disp_data <= (disp_idx < NUM_A) ? active[d_idx] : '0;
    end

endmodule
